// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM encoding and frame constants.
// Imported by the loader top and its word assembler.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam int LEN_BYTES     = 2;
  localparam int WORD_BYTES    = 4;
  localparam int MEM_WORDS_DEF = 256;

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler with a one-cycle word_valid pulse.
// word_valid follows the cycle in which the last byte of a word arrived.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  idx,
  output logic        word_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      idx        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        word <= '0;
        idx  <= '0;
      end else if (en) begin
        word       <= {word[23:0], din};
        idx        <= idx + 2'd1;
        word_valid <= (idx == 2'(WORD_BYTES - 1));
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing big-endian words to instruction memory.
// Keeps the processor in reset until a load finishes with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                MEM_WORDS = MEM_WORDS_DEF,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LW = 8 * LEN_BYTES;

  state_t          state;
  state_t          nxt;
  logic [7:0]      len_hi;
  logic [LW-1:0]   len_n;
  logic [LW-1:0]   nwords;
  logic [LW-1:0]   wcnt;
  logic [7:0]      chk;
  logic [1:0]      idx;
  logic            acc;
  logic            go;
  logic            data_acc;
  logic            word_last;

  assign acc       = in_valid && in_ready;
  assign go        = start && !busy;
  assign data_acc  = acc && (state == S_DATA);
  assign word_last = data_acc && (idx == 2'(WORD_BYTES - 1));
  assign len_n     = {len_hi, in_data};

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst),
    .clr        (go),
    .en         (data_acc),
    .din        (in_data),
    .word       (mem_wdata),
    .idx        (idx),
    .word_valid (mem_we)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) nxt = S_LEN_HI;
      S_LEN_HI:
        if (acc) nxt = S_LEN_LO;
      S_LEN_LO:
        if (acc) begin
          if (len_n == '0)                 nxt = S_CHK;
          else if (32'(len_n) > MEM_WORDS) nxt = S_ERR;
          else                             nxt = S_DATA;
        end
      S_DATA:
        if (word_last && (wcnt + 1'b1 == nwords)) nxt = S_CHK;
      S_CHK:
        if (acc) nxt = (in_data == chk) ? S_DONE : S_ERR;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_rst  = 1'b1;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Address advances on the write itself, so the next word's byte
  // can be taken in the same cycle without a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi   <= '0;
      nwords   <= '0;
      wcnt     <= '0;
      chk      <= '0;
      mem_addr <= BASE_ADDR;
    end else if (go) begin
      wcnt     <= '0;
      chk      <= '0;
      mem_addr <= BASE_ADDR;
    end else begin
      if (acc && state == S_LEN_HI) len_hi <= in_data;
      if (acc && state == S_LEN_LO) nwords <= len_n;
      if (data_acc)                 chk    <= chk ^ in_data;
      if (word_last)                wcnt   <= wcnt + 1'b1;
      if (mem_we)
        mem_addr <= mem_addr + ADDR_W'(WORD_BYTES);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus,
// compared as mem_we strobes appear.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int nwr = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (rst && mem_we) begin
      nwr++;
      if (q.size() == 0) begin
        check("unexp_we", 64'(mem_we), 64'd0);
      end else begin
        e = q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.a));
        check("wr_data", 64'(mem_wdata), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      check("rdy_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      if (thr) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] bs[$], input bit thr);
    foreach (bs[i]) send_byte(bs[i], thr);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ready"}, 64'(in_ready), 64'd0);
    check({pfx, "_we"},    64'(mem_we), 64'd0);
    check({pfx, "_addr"},  64'(mem_addr), 64'd0);
    check({pfx, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({pfx, "_busy"},  64'(busy), 64'd0);
    check({pfx, "_done"},  64'(done), 64'd0);
    check({pfx, "_err"},   64'(err), 64'd0);
    check({pfx, "_cpurst"}, 64'(cpu_rst), 64'd1);
  endtask

  task automatic check_end(input string pfx, input bit ok,
                           input int wr0, input int nexp);
    tick();
    tick();
    check({pfx, "_done"},   64'(done), 64'(ok));
    check({pfx, "_err"},    64'(err), 64'(!ok));
    check({pfx, "_cpurst"}, 64'(cpu_rst), 64'(!ok));
    check({pfx, "_busy"},   64'(busy), 64'd0);
    check({pfx, "_ready"},  64'(in_ready), 64'd0);
    check({pfx, "_nwr"},    64'(nwr - wr0), 64'(nexp));
    check({pfx, "_qempty"}, 64'(q.size()), 64'd0);
  endtask

  task automatic run_prog(input string pfx, input logic [7:0] ck,
                          input bit thr);
    logic [7:0] f[$];
    int w0;
    w0 = nwr;
    f = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h01,
          8'h08, 8'h00, 8'h00, 8'h00, ck};
    q.push_back({32'h0, 32'h2000_0001});
    q.push_back({32'h4, 32'h0800_0000});
    do_start();
    check({pfx, "_busy0"}, 64'(busy), 64'd1);
    send_frame(f, thr);
    check_end(pfx, ck == 8'h29, w0, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] f[$];
    int w0;
    #3;
    check_reset_vals("rst");
    tick();
    rst = 1'b1;
    tick();
    check_reset_vals("idle");

    run_prog("good", 8'h29, 1'b0);

    // start ignored while busy
    q.push_back({32'h0, 32'h2000_0001});
    q.push_back({32'h4, 32'h0800_0000});
    w0 = nwr;
    do_start();
    f = '{8'h00, 8'h02, 8'h20, 8'h00};
    send_frame(f, 1'b0);
    start = 1'b1;
    f = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00};
    send_frame(f, 1'b0);
    start = 1'b0;
    send_byte(8'h29, 1'b0);
    check_end("busystart", 1'b1, w0, 2);

    run_prog("badck", 8'h28, 1'b0);

    w0 = nwr;
    do_start();
    f = '{8'h01, 8'h01};
    send_frame(f, 1'b0);
    check("toolong_err_now", 64'(err), 64'd1);
    check_end("toolong", 1'b0, w0, 0);

    w0 = nwr;
    do_start();
    f = '{8'h00, 8'h00, 8'h00};
    send_frame(f, 1'b0);
    check_end("len0", 1'b1, w0, 0);

    run_prog("thr", 8'h29, 1'b1);

    w0 = nwr;
    q.push_back({32'h0, 32'h2000_0001});
    do_start();
    f = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
    send_frame(f, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    check_reset_vals("postrst");
    check("midrst_nwr", 64'(nwr - w0), 64'd1);
    check("midrst_q", 64'(q.size()), 64'd0);

    run_prog("again", 8'h29, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
